dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LAT, default 2, memory access latency in cycles; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive pipeline grants while DMA waits; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 p_req  input  1  pipeline memory-stage access request; held until p_done.
REQ-006 p_we  input  1  pipeline write enable (1 = store, 0 = load).
REQ-007 p_addr  input  64  pipeline byte address.
REQ-008 p_wdata  input  64  pipeline store data.
REQ-009 p_rdata  output  64  pipeline load data; valid while p_done=1.
REQ-010 p_done  output  1  one-cycle completion pulse for pipeline access.
REQ-011 stall_m  output  1  stall to pipeline memory stage.
REQ-012 d_req  input  1  DMA/loader access request; held until d_done.
REQ-013 d_we  input  1  DMA write enable.
REQ-014 d_addr  input  64  DMA byte address.
REQ-015 d_wdata  input  64  DMA store data.
REQ-016 d_rdata  output  64  DMA load data; valid while d_done=1.
REQ-017 d_done  output  1  one-cycle completion pulse for DMA access.
REQ-018 m_en  output  1  memory access enable.
REQ-019 m_we  output  1  memory write strobe.
REQ-020 m_addr  output  64  memory address.
REQ-021 m_wdata  output  64  memory write data.
REQ-022 m_rdata  input  64  memory read data.
REQ-023 owner  output  1  current grant owner (0 = pipeline, 1 = DMA); meaningful in BUSY/RESP.

Function
REQ-024 FSM states IDLE, BUSY, RESP; arbitration SHALL occur only in IDLE.
REQ-025 IDLE: if p_req or d_req, at next edge go to BUSY, latch owner, we/addr/wdata of winner, load cnt=LAT-1; else stay IDLE.
REQ-026 Arbitration: pipeline wins by default; DMA wins if d_req and (p_req=0 or starve_cnt==STARVE_MAX).
REQ-027 starve_cnt (3 bits): increments on pipeline grant with d_req=1; clears on pipeline grant with d_req=0 and on any DMA grant; saturates at STARVE_MAX.
REQ-028 BUSY: m_en=1, m_addr/m_wdata from latched request; cnt decrements each cycle; m_we=1 only in the BUSY cycle where cnt==0 and latched we=1.
REQ-029 BUSY with cnt==0: at edge capture m_rdata into owner's rdata register (loads only; stores leave it unchanged), go to RESP.
REQ-030 RESP: assert owner's done for exactly one cycle, m_en=0, then go IDLE.
REQ-031 Latency: request sampled in IDLE at cycle k -> BUSY cycles k+1..k+LAT -> done at cycle k+LAT+1.
REQ-032 stall_m = p_req & ~p_done (combinational); stall_m=0 while p_req=0.
REQ-033 Request inputs changed or dropped during BUSY/RESP SHALL be ignored; the latched access completes and done still pulses.
REQ-034 Outside BUSY: m_en=0, m_we=0; m_addr/m_wdata hold last driven values.
REQ-035 p_rdata/d_rdata SHALL hold their value between completions.

Reset
REQ-036 rst=1 at an edge: state=IDLE, cnt=0, starve_cnt=0, owner=0, p_rdata=d_rdata=m_addr=m_wdata=0, p_done=d_done=m_en=m_we=0; takes priority over all transitions.
REQ-037 rst during BUSY/RESP SHALL abort the access: no done pulse, no m_we after the reset edge.

Verification
REQ-038 LAT=2, p_req load addr 0x10 at cycle 0, m_rdata=0xDEAD -> m_en=1 cycles 1-2, p_done=1 cycle 3, p_rdata=0xDEAD, stall_m=1 cycles 0-2, 0 at 3.
REQ-039 LAT=2, p_req store addr 0x20 data 0x55 -> m_we=1 only cycle 2 with m_addr=0x20, m_wdata=0x55; p_done cycle 3.
REQ-040 STARVE_MAX=2, p_req and d_req held continuously (reasserted after each done) -> grant order P,P,D,P,P,D.
REQ-041 d_req only, LAT=3, load m_rdata=0x1234 -> d_done at cycle 4, d_rdata=0x1234, p_done=0, stall_m=0.
REQ-042 rst=1 in BUSY cycle 1 (LAT=3) -> state IDLE at cycle 2, m_en=0, no p_done ever.
REQ-043 p_req dropped in BUSY cycle 1 -> p_done still pulses once at cycle LAT+1; no further grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one fixed-latency memory port between the
// pipeline memory stage and a DMA/loader master, with DMA starvation relief.
module dmem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [63:0] p_addr,
    input  logic [63:0] p_wdata,
    output logic [63:0] p_rdata,
    output logic        p_done,
    output logic        stall_m,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  starve_cnt;
    logic        lat_we;
    logic        any_req;
    logic        grant_d;
    logic        cnt_zero;
    logic        starved;

    assign any_req  = p_req | d_req;
    assign cnt_zero = (cnt == 4'd0);
    assign starved  = (starve_cnt == 3'(STARVE_MAX));

    // DMA wins when the pipeline is quiet or has hogged the port long enough
    assign grant_d = d_req & (~p_req | starved);

    // Stall the memory stage until its access completes
    assign stall_m = p_req & ~p_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, count down latency in BUSY, one RESP cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: memory strobes during BUSY, done pulse to the owner in RESP
    always_comb begin
        m_en   = 1'b0;
        m_we   = 1'b0;
        p_done = 1'b0;
        d_done = 1'b0;
        case (state)
            BUSY: begin
                m_en = 1'b1;
                m_we = lat_we & cnt_zero;
            end
            RESP: begin
                p_done = ~owner;
                d_done = owner;
            end
            default: begin
                m_en = 1'b0;
            end
        endcase
    end

    // Datapath: latch the winner, track starvation, capture load data
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            starve_cnt <= 3'd0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            m_addr     <= 64'd0;
            m_wdata    <= 64'd0;
            p_rdata    <= 64'd0;
            d_rdata    <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= grant_d;
                        lat_we  <= grant_d ? d_we : p_we;
                        m_addr  <= grant_d ? d_addr : p_addr;
                        m_wdata <= grant_d ? d_wdata : p_wdata;
                        cnt     <= 4'(LAT - 1);
                        if (grant_d || !d_req) begin
                            starve_cnt <= 3'd0;
                        end else if (!starved) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        if (!lat_we) begin
                            if (owner) begin
                                d_rdata <= m_rdata;
                            end else begin
                                p_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory behind the port,
// expected read data queued at issue and compared on each done pulse.
module tb_dmem_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 2;

    typedef struct {
        logic        we;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        p_req;
    logic        p_we;
    logic [63:0] p_addr;
    logic [63:0] p_wdata;
    logic [63:0] p_rdata;
    logic        p_done;
    logic        stall_m;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        m_en;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        owner;

    logic [63:0] mem [0:255];
    logic [63:0] sh  [0:255];
    logic        mem_load;

    exp_t        p_q [$];
    exp_t        d_q [$];
    logic        grants [$];
    logic        log_en;
    logic        m_en_q;
    logic [63:0] p_last;
    logic [63:0] d_last;
    int          n_chk;
    int          n_fail;
    int          n_grant;
    int          n_pdone;

    dmem_arbiter #(
        .LAT        (LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_req   (p_req),
        .p_we    (p_we),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .p_done  (p_done),
        .stall_m (stall_m),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i);
        if (i == 2)
            return 64'hDEAD;
        if (i == 128)
            return 64'h1234;
        return 64'hC0FF_EE00_0000_0000 | 64'(i * 7);
    endfunction

    assign m_rdata = mem[m_addr[10:3]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= pat(i);
        end else if (m_we) begin
            mem[m_addr[10:3]] <= m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_last = 64'd0;
            d_last = 64'd0;
        end
        if (m_en && !m_en_q) begin
            n_grant++;
            if (log_en)
                grants.push_back(owner);
        end
        m_en_q = m_en;
        if (p_done) begin
            n_pdone++;
            if (p_q.size() == 0) begin
                chk("p_spurious", 1, 0);
            end else begin
                e = p_q.pop_front();
                if (!e.we)
                    p_last = e.data;
                chk("p_rdata", p_rdata, p_last);
            end
        end
        if (d_done) begin
            if (d_q.size() == 0) begin
                chk("d_spurious", 1, 0);
            end else begin
                e = d_q.pop_front();
                if (!e.we)
                    d_last = e.data;
                chk("d_rdata", d_rdata, d_last);
            end
        end
    end

    task automatic p_drive(input logic we, input logic [63:0] a,
                           input logic [63:0] wd);
        exp_t e;
        p_req = 1'b1;
        p_we = we;
        p_addr = a;
        p_wdata = wd;
        e.we = we;
        if (we) begin
            sh[a[10:3]] = wd;
            e.data = wd;
        end else begin
            e.data = sh[a[10:3]];
        end
        p_q.push_back(e);
    endtask

    task automatic d_drive(input logic we, input logic [63:0] a,
                           input logic [63:0] wd);
        exp_t e;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        e.we = we;
        if (we) begin
            sh[a[10:3]] = wd;
            e.data = wd;
        end else begin
            e.data = sh[a[10:3]];
        end
        d_q.push_back(e);
    endtask

    task automatic wait_done(input logic is_d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? d_done : p_done;
        end
        if (!seen)
            chk(is_d ? "d_timeout" : "p_timeout", 0, 1);
    endtask

    task automatic p_go(input logic we, input logic [63:0] a,
                        input logic [63:0] wd);
        p_drive(we, a, wd);
        wait_done(1'b0);
        p_req = 1'b0;
    endtask

    task automatic d_go(input logic we, input logic [63:0] a,
                        input logic [63:0] wd);
        d_drive(we, a, wd);
        wait_done(1'b1);
        d_req = 1'b0;
    endtask

    task automatic lat_p(input logic we, input logic [63:0] a,
                         input logic [63:0] wd);
        @(negedge clk);
        p_drive(we, a, wd);
        #1;
        chk("stall_c0", stall_m, 1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("m_en_busy", m_en, 1);
            chk("m_we_busy", m_we, (we && i == LAT));
            chk("m_addr_busy", m_addr, a);
            chk("stall_busy", stall_m, 1);
            chk("p_done_busy", p_done, 0);
            if (we && i == LAT)
                chk("m_wdata_busy", m_wdata, wd);
        end
        @(negedge clk);
        chk("p_done_resp", p_done, 1);
        chk("m_en_resp", m_en, 0);
        chk("stall_resp", stall_m, 0);
        p_req = 1'b0;
    endtask

    task automatic lat_d(input logic [63:0] a);
        @(negedge clk);
        d_drive(1'b0, a, 64'd0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("d_m_en_busy", m_en, 1);
            chk("d_owner", owner, 1);
            chk("d_stall", stall_m, 0);
        end
        @(negedge clk);
        chk("d_done_resp", d_done, 1);
        chk("d_no_pdone", p_done, 0);
        chk("d_stall_resp", stall_m, 0);
        d_req = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] wd;
        int cyc;
        int g0;
        int pd0;
        n_chk = 0;
        n_fail = 0;
        n_grant = 0;
        n_pdone = 0;
        log_en = 1'b0;
        m_en_q = 1'b0;
        p_last = 64'd0;
        d_last = 64'd0;
        rst = 1'b1;
        mem_load = 1'b1;
        p_req = 1'b0;
        p_we = 1'b0;
        p_addr = 64'd0;
        p_wdata = 64'd0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = 64'd0;
        d_wdata = 64'd0;
        for (int i = 0; i < 256; i++)
            sh[i] = pat(i);
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        chk("rst_m_en", m_en, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_p_done", p_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_stall", stall_m, 0);
        rst = 1'b0;

        lat_p(1'b0, 64'h10, 64'd0);
        chk("load_dead", p_rdata, 64'hDEAD);
        lat_p(1'b1, 64'h20, 64'h55);
        @(negedge clk);
        chk("idle_m_we", m_we, 0);
        chk("idle_m_addr_hold", m_addr, 64'h20);
        chk("idle_m_wdata_hold", m_wdata, 64'h55);
        lat_d(64'h400);
        chk("dload_1234", d_rdata, 64'h1234);

        for (int i = 0; i < 4; i++) begin
            a = 64'($urandom_range(8, 127)) * 64'd8;
            wd = {$urandom, $urandom};
            p_go(1'b1, a, wd);
            p_go(1'b0, a, 64'd0);
            d_go(1'b1, a + 64'h400, ~wd);
            d_go(1'b0, a + 64'h400, 64'd0);
            p_go(1'b0, 64'h10 + 64'(i) * 64'd8, 64'd0);
        end

        @(negedge clk);
        p_drive(1'b0, 64'h30, 64'd0);
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        p_req = 1'b0;
        for (int i = 0; i < 20 && !p_done; i++) begin
            @(negedge clk);
            cyc++;
        end
        chk("drop_lat", 64'(cyc), 64'(LAT + 1));
        g0 = n_grant;
        repeat (6) @(negedge clk);
        chk("drop_nogrant", 64'(n_grant), 64'(g0));

        grants.delete();
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    p_drive(1'b0, 64'h100 + 64'(i) * 64'd8, 64'd0);
                    wait_done(1'b0);
                end
                p_req = 1'b0;
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    d_drive(1'b0, 64'h500 + 64'(i) * 64'd8, 64'd0);
                    wait_done(1'b1);
                end
                d_req = 1'b0;
            end
        join
        log_en = 1'b0;
        chk("starve_n", 64'(grants.size()), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("starve_g%0d", i), grants[i],
                (i == 2 || i == 5) ? 1 : 0);

        @(negedge clk);
        p_req = 1'b1;
        p_we = 1'b0;
        p_addr = 64'h40;
        @(negedge clk);
        chk("abort_busy", m_en, 1);
        rst = 1'b1;
        p_req = 1'b0;
        @(negedge clk);
        chk("abort_m_en", m_en, 0);
        chk("abort_m_we", m_we, 0);
        chk("abort_p_rdata", p_rdata, 0);
        chk("abort_m_addr", m_addr, 0);
        rst = 1'b0;
        pd0 = n_pdone;
        repeat (LAT + 4) @(negedge clk);
        chk("abort_nodone", 64'(n_pdone), 64'(pd0));
        chk("abort_m_en_idle", m_en, 0);
        chk("p_q_empty", 64'(p_q.size()), 0);
        chk("d_q_empty", 64'(d_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
